// File: rtl/step_ramp_generator.sv
// Step/direction motion profiler: accepts signed relative moves and emits STEP1/DIR1
// with a DIR setup delay, fixed pulse width and a symmetric linear period ramp.
module step_ramp_generator #(
    parameter int MOVE_W       = 16,
    parameter int PER_W        = 24,
    parameter int POS_W        = 32,
    parameter int PULSE_W      = 50,
    parameter int DIR_SETUP    = 100,
    parameter int START_PERIOD = 50000,
    parameter int MIN_PERIOD   = 5000,
    parameter int ACCEL_DEC    = 100
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     CMD_VALID,
    output logic                     CMD_READY,
    input  logic signed [MOVE_W-1:0] CMD_STEPS,
    input  logic                     ABORT,
    output logic                     STEP1,
    output logic                     DIR1,
    output logic                     BUSY,
    output logic                     DONE,
    output logic                     ABORTED,
    output logic signed [POS_W-1:0]  POSITION
);

    typedef enum logic [2:0] {
        IDLE,
        DIR_SET,
        STEP_HI,
        STEP_LO,
        FINISH
    } state_t;

    state_t                    state, state_next;
    logic [PER_W-1:0]          timer, timer_next;
    logic [PER_W-1:0]          period, period_next;
    logic [PER_W-1:0]          cur_period, cur_period_next;
    logic [MOVE_W-1:0]         remaining, remaining_next;
    logic [MOVE_W-1:0]         ramp_cnt, ramp_next;
    logic                      dir_next;
    logic signed [POS_W-1:0]   position_next;
    logic                      aborted_next;
    logic                      enter_step;

    logic [MOVE_W-1:0]         cmd_mag;
    logic [MOVE_W-1:0]         rem_dec;
    logic [PER_W:0]            period_sum;
    logic [PER_W-1:0]          period_up;
    logic [PER_W-1:0]          period_down;

    // Magnitude is taken as unsigned so the most negative command still fits.
    assign cmd_mag = CMD_STEPS[MOVE_W-1] ? $unsigned(-CMD_STEPS) : $unsigned(CMD_STEPS);
    assign rem_dec = remaining - MOVE_W'(1);

    // Both ramp directions saturate, so a large ACCEL_DEC never wraps the period.
    assign period_sum  = {1'b0, period} + (PER_W+1)'(ACCEL_DEC);
    assign period_up   = (period_sum >= (PER_W+1)'(START_PERIOD)) ? PER_W'(START_PERIOD)
                                                                  : period_sum[PER_W-1:0];
    assign period_down = ({1'b0, period} <= (PER_W+1)'(MIN_PERIOD) + (PER_W+1)'(ACCEL_DEC))
                         ? PER_W'(MIN_PERIOD) : period - PER_W'(ACCEL_DEC);

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case leaves a latch.
        state_next      = state;
        timer_next      = timer;
        period_next     = period;
        cur_period_next = cur_period;
        remaining_next  = remaining;
        ramp_next       = ramp_cnt;
        dir_next        = DIR1;
        position_next   = POSITION;
        aborted_next    = 1'b0;
        enter_step      = 1'b0;

        case (state)
            IDLE: begin
                if (CMD_VALID) begin
                    if (CMD_STEPS == '0) begin
                        state_next = FINISH;
                    end else begin
                        dir_next       = ~CMD_STEPS[MOVE_W-1];
                        remaining_next = cmd_mag;
                        period_next    = PER_W'(START_PERIOD);
                        ramp_next      = '0;
                        timer_next     = PER_W'(DIR_SETUP - 1);
                        state_next     = DIR_SET;
                    end
                end
            end
            DIR_SET: begin
                if (ABORT) begin
                    state_next   = FINISH;
                    aborted_next = 1'b1;
                end else if (timer == '0) begin
                    enter_step = 1'b1;
                end else begin
                    timer_next = timer - PER_W'(1);
                end
            end
            STEP_HI: begin
                if (timer == '0) begin
                    state_next = STEP_LO;
                    timer_next = cur_period - PER_W'(PULSE_W + 1);
                end else begin
                    timer_next = timer - PER_W'(1);
                end
            end
            STEP_LO: begin
                if (timer == '0) begin
                    if (remaining != '0 && !ABORT) begin
                        enter_step = 1'b1;
                    end else begin
                        state_next   = FINISH;
                        aborted_next = ABORT && (remaining != '0);
                    end
                end else begin
                    timer_next = timer - PER_W'(1);
                end
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // Step entry: the period in force now governs this step; the ramp picks the next one.
        if (enter_step) begin
            state_next      = STEP_HI;
            timer_next      = PER_W'(PULSE_W - 1);
            cur_period_next = period;
            position_next   = DIR1 ? POSITION + POS_W'(1) : POSITION - POS_W'(1);
            remaining_next  = rem_dec;
            if (rem_dec <= ramp_cnt) begin
                period_next = period_up;
                if (ramp_cnt != '0) ramp_next = ramp_cnt - MOVE_W'(1);
            end else if (period > PER_W'(MIN_PERIOD)) begin
                period_next = period_down;
                ramp_next   = ramp_cnt + MOVE_W'(1);
            end
        end
    end

    // Outputs are registered from the next state so STEP1 is a clean flop output.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments only; reset clears the whole datapath.
        if (RST) begin
            state      <= IDLE;
            timer      <= '0;
            period     <= PER_W'(START_PERIOD);
            cur_period <= PER_W'(START_PERIOD);
            remaining  <= '0;
            ramp_cnt   <= '0;
            STEP1      <= 1'b0;
            DIR1       <= 1'b1;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            ABORTED    <= 1'b0;
            CMD_READY  <= 1'b1;
            POSITION   <= '0;
        end else begin
            state      <= state_next;
            timer      <= timer_next;
            period     <= period_next;
            cur_period <= cur_period_next;
            remaining  <= remaining_next;
            ramp_cnt   <= ramp_next;
            STEP1      <= (state_next == STEP_HI);
            DIR1       <= dir_next;
            BUSY       <= (state_next == DIR_SET) || (state_next == STEP_HI) || (state_next == STEP_LO);
            DONE       <= (state_next == FINISH);
            ABORTED    <= aborted_next;
            CMD_READY  <= (state_next == IDLE);
            POSITION   <= position_next;
        end
    end

endmodule
